// File: rtl/demux_pkg.sv
// Shared types for the 1x4 TDM demultiplexer.
// Slot indexing and lock states used by the top and the slot counter.
package demux_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the TDM demux.
// Load-to-1 wins over clear, clear wins over increment.
module tdm_slot_ctr
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t cnt
);

    slot_t cnt_q;
    slot_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load1) begin
            cnt_d = slot_t'(1);
        end else if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + slot_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/demux_1x4_tdm.sv
// 1x4 TDM demultiplexer with sync tracking and flywheel lock.
// Frames are assembled in shadows and published on the slot-3 sample.
module demux_1x4_tdm
    import demux_pkg::*;
#(
    parameter int W          = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [1:0]   s,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    localparam int MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

    state_e state_q, state_d;
    slot_t  cnt;
    slot_t  slot;
    logic   in_lock, miss0, realign, lose, take, fire, ctr_clr;

    logic [MW-1:0] miss_q, miss_d;
    logic [NUM_SLOTS-2:0][W-1:0] sh_q, sh_d;
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic [W-1:0] a_d, b_d, c_d, d_d;
    logic fv_q, fv_d;

    tdm_slot_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .load1 (sync),
        .inc   (in_lock),
        .cnt   (cnt)
    );

    always_comb begin
        in_lock = (state_q == LOCKED);
        slot    = sync ? '0 : cnt;
        miss0   = in_lock && !sync && (cnt == '0);
        realign = in_lock && sync && (cnt != '0);
        lose    = miss0 && (int'(miss_q) + 1 >= MISS_LIMIT);
        take    = (in_lock || sync) && !lose;
        fire    = in_lock && !sync && (cnt == LAST_SLOT);
        ctr_clr = !in_lock || lose;

        state_d = state_q;
        if (sync) begin
            state_d = LOCKED;
        end else if (lose) begin
            state_d = HUNT;
        end

        miss_d = miss_q;
        if (sync || lose) begin
            miss_d = '0;
        end else if (miss0) begin
            miss_d = miss_q + MW'(1);
        end

        sh_d = sh_q;
        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (take && slot == slot_t'(i)) begin
                sh_d[i] = din;
            end
        end

        // slot 3 bypasses the shadows and goes straight to d
        a_d  = a_q;
        b_d  = b_q;
        c_d  = c_q;
        d_d  = d_q;
        fv_d = fire;
        if (fire) begin
            a_d = sh_q[0];
            b_d = sh_q[1];
            c_d = sh_q[2];
            d_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            miss_q  <= '0;
            sh_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            sh_q    <= sh_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            fv_q    <= fv_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign s           = slot;
    assign frame_valid = fv_q;
    assign locked      = in_lock;
    assign sync_err    = miss0 || realign;

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Bench for demux_1x4_tdm: W=1 and W=4 instances against a frame-level model.
// Directed scenarios pin the model, then random sync patterns exercise it.
module tb_demux_1x4_tdm;

    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       din1 = 1'b0;
    logic [3:0] din4 = 4'h0;

    logic       a1, b1, c1, d1;
    logic [1:0] s1;
    logic       fv1, lk1, se1;
    logic [3:0] a4, b4, c4, d4;
    logic [1:0] s4;
    logic       fv4, lk4, se4;

    always #5 clk = ~clk;

    demux_1x4_tdm #(.W(1), .MISS_LIMIT(ML)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .sync(sync),
        .a(a1), .b(b1), .c(c1), .d(d1), .s(s1),
        .frame_valid(fv1), .locked(lk1), .sync_err(se1)
    );

    demux_1x4_tdm #(.W(4), .MISS_LIMIT(ML)) dut4 (
        .clk(clk), .rst(rst), .din(din4), .sync(sync),
        .a(a4), .b(b4), .c(c4), .d(d4), .s(s4),
        .frame_valid(fv4), .locked(lk4), .sync_err(se4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: pos = slot expected for the next sample, -1 while hunting
    int         pos;
    int         misses;
    logic       bf1 [4];
    logic [3:0] bf4 [4];
    logic       o1 [4];
    logic [3:0] o4 [4];
    logic       mfv;
    logic       e_lk, e_err;
    int         e_s;

    function automatic void model_reset();
        pos    = -1;
        misses = 0;
        mfv    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bf1[i] = 1'b0; bf4[i] = 4'h0;
            o1[i]  = 1'b0; o4[i]  = 4'h0;
        end
    endfunction

    function automatic void model_comb();
        e_lk  = (pos >= 0);
        e_s   = (sync || pos < 0) ? 0 : pos;
        e_err = (pos >= 0) && (sync ? (pos != 0) : (pos == 0));
    endfunction

    function automatic void model_edge();
        logic nfv;
        nfv = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (sync) begin
            bf1[0] = din1; bf4[0] = din4;
            pos = 1;
            misses = 0;
        end else if (pos >= 0) begin
            if (pos == 0) misses++;
            if (pos == 0 && misses >= ML) begin
                pos = -1;
                misses = 0;
            end else begin
                bf1[pos] = din1; bf4[pos] = din4;
                if (pos == 3) begin
                    for (int i = 0; i < 4; i++) begin
                        o1[i] = bf1[i]; o4[i] = bf4[i];
                    end
                    nfv = 1'b1;
                end
                pos = (pos + 1) % 4;
            end
        end
        mfv = nfv;
    endfunction

    always @(negedge clk) begin
        chk("lk1", lk1, e_lk);   chk("lk4", lk4, e_lk);
        chk("s1", s1, e_s);      chk("s4", s4, e_s);
        chk("err1", se1, e_err); chk("err4", se4, e_err);
        chk("fv1", fv1, mfv);    chk("fv4", fv4, mfv);
        chk("a1", a1, o1[0]); chk("b1", b1, o1[1]);
        chk("c1", c1, o1[2]); chk("d1", d1, o1[3]);
        chk("a4", a4, o4[0]); chk("b4", b4, o4[1]);
        chk("c4", c4, o4[2]); chk("d4", d4, o4[3]);
    end

    int cyc = 0;
    int err_seen = 0;
    int fvq[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (se1) err_seen++;
        if (fv1) fvq.push_back(cyc);
    end

    task automatic step(input logic sy, input logic dv1, input logic [3:0] dv4);
        @(posedge clk);
        model_edge();
        #1;
        sync = sy; din1 = dv1; din4 = dv4;
        model_comb();
        @(negedge clk);
    endtask

    task automatic rst_on();
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b1; sync = 1'b0;
        model_reset();
        model_comb();
        @(negedge clk);
    endtask

    task automatic rst_off();
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
        model_comb();
        @(negedge clk);
    endtask

    task automatic frame_out(input string tg, input logic [3:0] pb, input logic [15:0] pn);
        chk({tg, "_fv"}, fv1, 1'b1);
        chk({tg, "_lk"}, lk1, 1'b1);
        chk({tg, "_a"}, a1, pb[3]); chk({tg, "_b"}, b1, pb[2]);
        chk({tg, "_c"}, c1, pb[1]); chk({tg, "_d"}, d1, pb[0]);
        chk({tg, "_a4"}, a4, pn[15:12]); chk({tg, "_b4"}, b4, pn[11:8]);
        chk({tg, "_c4"}, c4, pn[7:4]);   chk({tg, "_d4"}, d4, pn[3:0]);
    endtask

    task automatic frame(input logic sy0, input logic [3:0] bits, input logic [15:0] nib,
                         input bit chkp, input logic [3:0] pb, input logic [15:0] pn,
                         input string tg);
        step(sy0, bits[3], nib[15:12]);
        if (chkp) frame_out(tg, pb, pn);
        step(1'b0, bits[2], nib[11:8]);
        step(1'b0, bits[1], nib[7:4]);
        step(1'b0, bits[0], nib[3:0]);
    endtask

    initial begin
        int e0;
        int nfv;
        logic sy;
        model_reset();
        model_comb();
        @(negedge clk);
        chk("rst_lk", lk1, 1'b0);
        chk("rst_fv", fv1, 1'b0);
        chk("rst_a4", a4, 4'h0);
        chk("rst_s", s1, 2'd0);
        rst_off();
        step(1'b0, 1'b1, 4'h7);
        chk("hunt_s", s1, 2'd0);
        chk("hunt_lk", lk1, 1'b0);

        frame(1'b1, 4'b1101, 16'hA50F, 1'b0, 4'b0, 16'h0, "");
        chk("f0_early_fv", fv1, 1'b0);
        e0 = err_seen;
        fvq.delete();
        frame(1'b1, 4'b0010, 16'h1234, 1'b1, 4'b1101, 16'hA50F, "f0");
        frame(1'b1, 4'b1111, 16'h5678, 1'b1, 4'b0010, 16'h1234, "f1");
        frame(1'b1, 4'b0110, 16'h9ABC, 1'b1, 4'b1111, 16'h5678, "f2");
        chk("b2b_no_err", err_seen - e0, 0);
        chk("b2b_fv_cnt", fvq.size(), 3);
        if (fvq.size() == 3) begin
            chk("b2b_gap1", fvq[1] - fvq[0], 4);
            chk("b2b_gap2", fvq[2] - fvq[1], 4);
        end

        step(1'b0, 1'b1, 4'h3);
        frame_out("f3", 4'b0110, 16'h9ABC);
        chk("miss1_err", se1, 1'b1);
        step(1'b0, 1'b0, 4'h4);
        step(1'b0, 1'b0, 4'h5);
        step(1'b0, 1'b1, 4'h6);
        step(1'b0, 1'b0, 4'h0);
        frame_out("fly", 4'b1001, 16'h3456);
        chk("miss2_err", se1, 1'b1);
        step(1'b0, 1'b1, 4'h1);
        chk("miss2_lk", lk1, 1'b0);
        chk("miss2_noerr", se1, 1'b0);

        nfv = fvq.size();
        step(1'b1, 1'b0, 4'h2);
        step(1'b0, 1'b1, 4'h2);
        step(1'b1, 1'b1, 4'hC);
        chk("re_err", se1, 1'b1);
        chk("re_s1", s1, 2'd0);
        chk("re_s4", s4, 2'd0);
        step(1'b0, 1'b0, 4'hD);
        step(1'b0, 1'b1, 4'hE);
        step(1'b0, 1'b1, 4'hF);
        chk("re_no_fv", fvq.size() - nfv, 0);
        step(1'b1, 1'b0, 4'h8);
        frame_out("re", 4'b1011, 16'hCDEF);

        step(1'b0, 1'b1, 4'h9);
        rst_on();
        chk("mid_rst_a", a1, 1'b0);
        chk("mid_rst_c", c1, 1'b0);
        chk("mid_rst_a4", a4, 4'h0);
        chk("mid_rst_lk", lk1, 1'b0);
        chk("mid_rst_fv", fv1, 1'b0);
        rst_off();
        chk("post_rst_lk", lk1, 1'b0);
        frame(1'b1, 4'b0111, 16'h0F0F, 1'b0, 4'b0, 16'h0, "");
        frame(1'b1, 4'b1000, 16'h1111, 1'b1, 4'b0111, 16'h0F0F, "relock");

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_on();
                if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 4'h0);
                rst_off();
            end
            if (pos == 0) sy = ($urandom_range(0, 9) != 0);
            else          sy = ($urandom_range(0, 24) == 0);
            step(sy, 1'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
